seq001_frame_tx: RTL and testbench

- Serial frame transmitter that produces the bit stream consumed by our "001" sequence-detector Mealy machines.
- Accepts a parallel word through a valid/ready handshake.
- Emits a sync marker "001" followed by the payload MSB-first, one bit per clock.
- Inserts a stuffed 1 after every payload 0, so "001" occurs on the line exactly once per frame: at the end of the sync marker.

---
 rtl/seq001_frame_tx_if.sv | 23 ++
 rtl/seq001_frame_tx.sv | 112 +++++++++++
 tb/tb_seq001_frame_tx.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/seq001_frame_tx_if.sv
// Handshake and serial-line bundle for seq001_frame_tx.
// The block is the slave: it accepts words and drives the serial line.
interface seq001_frame_tx_if #(
  parameter int DATA_W = 8
);
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;
  logic              ser_out;
  logic              ser_en;
  logic              busy;
  logic              frame_done;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, ser_out, ser_en, busy, frame_done
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, ser_out, ser_en, busy, frame_done
  );
endinterface

// File: rtl/seq001_frame_tx.sv
// Serial "001"-sync frame transmitter, first sync bit one cycle after accept, MSB-first payload with a 1 stuffed after every 0.
// tx_ready is high only in IDLE; tx_valid seen while a frame is in flight is ignored.
module seq001_frame_tx #(
  parameter int DATA_W = 8
) (
  input  logic clk,
  input  logic reset,
  seq001_frame_tx_if.slave bus
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC0 = 3'd1,
    SYNC1 = 3'd2,
    SYNC2 = 3'd3,
    DATA  = 3'd4,
    STUFF = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ser_out_q, ser_out_d;
  logic              ser_en_q, ser_en_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              last_bit;

  assign last_bit = (cnt_q == '0);

  // state_q names the bit currently on the line; outputs are computed for state_d
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.tx_valid) begin
          state_d = SYNC0;
          shreg_d = bus.tx_data;
          cnt_d   = '0;
        end
      end
      SYNC0: state_d = SYNC1;
      SYNC1: state_d = SYNC2;
      SYNC2: begin
        state_d = DATA;
        cnt_d   = CNT_W'(DATA_W - 1);
      end
      DATA: begin
        if (!shreg_q[DATA_W-1]) begin
          state_d = STUFF;
        end else if (last_bit) begin
          state_d = IDLE;
        end else begin
          shreg_d = shreg_q << 1;
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      STUFF: begin
        if (last_bit) begin
          state_d = IDLE;
        end else begin
          state_d = DATA;
          shreg_d = shreg_q << 1;
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    ser_en_d = (state_d != IDLE);
    busy_d   = (state_d != IDLE);
    if (state_d == DATA) begin
      ser_out_d = shreg_d[DATA_W-1];
    end else begin
      ser_out_d = !((state_d == SYNC0) || (state_d == SYNC1));
    end
    // The final frame bit is the last data bit when it is 1, otherwise its stuff bit.
    frame_done_d = ((state_d == DATA) && (cnt_d == '0) && shreg_d[DATA_W-1]) ||
                   ((state_d == STUFF) && (cnt_d == '0));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      ser_out_q    <= 1'b1;
      ser_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      ser_out_q    <= ser_out_d;
      ser_en_q     <= ser_en_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.tx_ready   = (state_q == IDLE);
  assign bus.ser_out    = ser_out_q;
  assign bus.ser_en     = ser_en_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seq001_frame_tx.sv
// Directed and random frames for seq001_frame_tx; a scoreboard queue holds the expected line bits per frame.
module tb_seq001_frame_tx;

  localparam int DW = 8;

  logic clk;
  logic reset;

  seq001_frame_tx_if #(.DATA_W(DW)) bus ();

  seq001_frame_tx #(.DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic b;
    logic done;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  int   idx      = 0;
  int   last_len = 0;
  int   done_cnt = 0;
  int   det_cnt  = 0;
  logic h1 = 1'b1;
  logic h2 = 1'b1;
  logic prev_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference line image of one frame: sync 001, then each payload bit, a 1 after every 0.
  task automatic push_frame(input logic [DW-1:0] w);
    exp_t e;
    e = '{b: 1'b0, done: 1'b0}; q.push_back(e);
    e = '{b: 1'b0, done: 1'b0}; q.push_back(e);
    e = '{b: 1'b1, done: 1'b0}; q.push_back(e);
    for (int i = DW - 1; i >= 0; i--) begin
      if (w[i]) begin
        e = '{b: 1'b1, done: (i == 0)}; q.push_back(e);
      end else begin
        e = '{b: 1'b0, done: 1'b0};     q.push_back(e);
        e = '{b: 1'b1, done: (i == 0)}; q.push_back(e);
      end
    end
  endtask

  // Line monitor with an ser_en-gated "001" Mealy detector.
  always @(negedge clk) begin
    exp_t e;
    logic det;
    if (reset) begin
      idx = 0; h1 = 1'b1; h2 = 1'b1; prev_done = 1'b0;
    end else begin
      if (prev_done) chk("ready_after_done", {bus.tx_ready, bus.ser_en}, 2'b10);
      if (bus.ser_en) begin
        if (q.size() == 0) begin
          chk("unexpected_bit", bus.ser_en, 0);
        end else begin
          e = q.pop_front();
          chk("line_bit", {bus.ser_out, bus.frame_done, bus.busy}, {e.b, e.done, 1'b1});
        end
        idx++;
        det = !h2 && !h1 && bus.ser_out;
        h2  = h1;
        h1  = bus.ser_out;
        chk("det_on_sync2", det, (idx == 3));
        if (det) det_cnt++;
        if (bus.frame_done) begin
          done_cnt++;
          last_len = idx;
        end
      end else begin
        chk("idle_line", {bus.ser_out, bus.busy, bus.frame_done}, 3'b100);
        idx = 0;
      end
      prev_done = bus.frame_done;
    end
  end

  task automatic wait_accept(output int n);
    logic acc;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 64) begin
      @(negedge clk);
      acc = bus.tx_ready;
      @(posedge clk);
      n++;
    end
    #1;
    chk("accept_timeout", acc, 1);
  endtask

  task automatic send(input logic [DW-1:0] w, input bit hold);
    int n;
    bus.tx_valid = 1'b1;
    bus.tx_data  = w;
    push_frame(w);
    wait_accept(n);
    if (!hold) bus.tx_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int done0;
    int det0;
    reset        = 1'b1;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    #2;
    chk("rst_ser_out", bus.ser_out, 1);
    chk("rst_ser_en", bus.ser_en, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    chk("rst_tx_ready", bus.tx_ready, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_after_reset", {bus.ser_out, bus.ser_en, bus.busy, bus.frame_done, bus.tx_ready}, 5'b10001);
    end
    @(posedge clk); #1;

    send(8'hA5, 1'b0);
    drain();
    chk("len_a5", last_len, 15);

    send(8'hFF, 1'b0);
    drain();
    chk("len_ff", last_len, 11);

    send(8'h00, 1'b0);
    drain();
    chk("len_00", last_len, 19);

    // Back-to-back with tx_valid held; tx_data changes mid-frame each time.
    send(8'h0F, 1'b1);
    bus.tx_data = 8'hF0;
    push_frame(8'hF0);
    wait_accept(n);
    chk("b2b_gap", n, 16);
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h33;
    drain();
    chk("len_f0", last_len, 15);

    // Abort during the 6th bit of a 0x55 frame.
    done0 = done_cnt;
    send(8'h55, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_line", {bus.ser_out, bus.ser_en, bus.busy, bus.frame_done, bus.tx_ready}, 5'b10001);
    q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_no_done", done_cnt, done0);
    send(8'h81, 1'b0);
    drain();
    chk("len_81", last_len, 17);

    done0 = done_cnt;
    det0  = det_cnt;
    for (int i = 0; i < 1000; i++) begin
      send(DW'($urandom_range(0, 255)), 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain();
    chk("rand_frames", done_cnt - done0, 1000);
    chk("rand_detects", det_cnt - det0, 1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
